// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, default LFSR constants and LFSR step function
package ram_bist_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
    localparam int unsigned DEF_SEED = 'h01;
    localparam int unsigned DEF_TAPS = 'hB8;
    function automatic logic [63:0] lfsr_step(input logic [63:0] v, input logic [63:0] taps);
        return v[0] ? (v >> 1) ^ taps : v >> 1;
    endfunction
endpackage

// File: rtl/ram_bist_lfsr.sv
// galois_lfsr: right-shifting Galois LFSR with synchronous reload to a seed that is never zero
module galois_lfsr
    import ram_bist_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned TAPS = DEF_TAPS,
    parameter int unsigned SEED = DEF_SEED
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         step_i,
    output logic [W-1:0] value_o
);
    localparam logic [W-1:0] TAPS_V = W'(TAPS);
    localparam logic [W-1:0] SEED_T = W'(SEED);
    localparam logic [W-1:0] SEED_V = (SEED_T == '0) ? W'(1) : SEED_T;
    logic [W-1:0] value_q, value_d;
    // reload wins over step so a restart always begins at the seed
    always_comb value_d = load_i ? SEED_V : step_i ? W'(lfsr_step(64'(value_q), 64'(TAPS_V))) : value_q;
    // LFSR register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) value_q <= SEED_V;
        else          value_q <= value_d;
    assign value_o = value_q;
endmodule

// File: rtl/ram_bist.sv
// ram_bist: RAM self-test that fills memory with an LFSR sequence then reads it back and compares; RAM_BIST_ERRCNT_EN adds err_count_o
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned SEED       = DEF_SEED,
    parameter int unsigned TAPS       = DEF_TAPS,
    localparam int unsigned ADDR_W    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_W-1:0]     fail_addr_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_wr_en_o,
    output logic [WORD_WIDTH-1:0] mem_data_o,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [ADDR_W:0]       err_count_o,
`endif
    input  logic [WORD_WIDTH-1:0] mem_data_i
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, fail_q, fail_d;
    logic pass_q, pass_d;
    logic [WORD_WIDTH-1:0] lfsr;
    logic go, last, miss, busy;
    assign go   = start_i && (state_q == IDLE || state_q == DONE);
    assign last = addr_q == ADDR_W'(WORDS - 1);
    assign busy = state_q == WRITE || state_q == READ;
    assign miss = state_q == READ && mem_data_i != lfsr;
    galois_lfsr #(.W(WORD_WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (go || (state_q == WRITE && last)),
        .step_i (busy),
        .value_o(lfsr)
    );
    // sequencing: counter walks the array once for write and once for read; only the first mismatch is latched
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        if (go) begin
            state_d = WRITE;
            addr_d  = '0;
        end else if (busy) begin
            addr_d = last ? '0 : addr_q + 1'b1;
            if (state_q == WRITE && last) begin
                state_d = READ;
                pass_d  = 1'b1;
                fail_d  = '0;
            end
            if (miss && pass_q) begin
                pass_d = 1'b0;
                fail_d = addr_q;
            end
            if (state_q == READ && last) state_d = DONE;
        end
    end
    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pass_q  <= 1'b1;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
`ifdef RAM_BIST_ERRCNT_EN
    logic [ADDR_W:0] err_q, err_d;
    // mismatch counter, saturating at the array depth
    always_comb err_d = go ? '0 : (miss && err_q != (ADDR_W+1)'(WORDS)) ? err_q + 1'b1 : err_q;
    // mismatch counter register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) err_q <= '0;
        else          err_q <= err_d;
    assign err_count_o = err_q;
`endif
    assign busy_o      = busy;
    assign done_o      = state_q == DONE;
    assign pass_o      = state_q == DONE && pass_q;
    assign fail_addr_o = fail_q;
    assign mem_wr_en_o = state_q == WRITE;
    assign mem_addr_o  = busy ? addr_q : '0;
    assign mem_data_o  = state_q == WRITE ? lfsr : '0;
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed table-driven bench for ram_bist with a behavioural RAM and read-fault injection
module tb_ram_bist;
    logic clk = 0, reset_n = 0, start_i = 0, start0 = 0;
    logic busy_o, done_o, pass_o, mem_wr_en_o;
    logic [3:0] fail_addr_o, mem_addr_o;
    logic [7:0] mem_data_o, mem_data_i;
    logic busy0, done0, pass0, wr0;
    logic [3:0] fa0, addr0;
    logic [7:0] wdata0, rdata0;
`ifdef RAM_BIST_ERRCNT_EN
    logic [4:0] err_count_o, err0;
`endif
    logic [7:0] mem [16];
    logic [7:0] mem0 [16];
    logic [15:0] flip_mask = '0;
    int total = 0, bad = 0;
    typedef struct {
        logic       start;
        logic       busy;
        logic       done;
        logic       pass;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t tbl [34];
    logic [7:0] seq [16] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8,
                             8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57};

    always #5 clk = ~clk;

    ram_bist #(.WORDS(16), .WORD_WIDTH(8), .SEED('h01), .TAPS('hB8)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .fail_addr_o(fail_addr_o), .mem_addr_o(mem_addr_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_data_o(mem_data_o),
`ifdef RAM_BIST_ERRCNT_EN
        .err_count_o(err_count_o),
`endif
        .mem_data_i(mem_data_i));

    ram_bist #(.WORDS(16), .WORD_WIDTH(8), .SEED(0), .TAPS('hB8)) dut0 (
        .clk(clk), .reset_n(reset_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .pass_o(pass0), .fail_addr_o(fa0), .mem_addr_o(addr0),
        .mem_wr_en_o(wr0), .mem_data_o(wdata0),
`ifdef RAM_BIST_ERRCNT_EN
        .err_count_o(err0),
`endif
        .mem_data_i(rdata0));

    always @(posedge clk) begin
        if (mem_wr_en_o) mem[mem_addr_o] <= mem_data_o;
        if (wr0) mem0[addr0] <= wdata0;
    end
    assign mem_data_i = mem[mem_addr_o] ^ {7'b0, !mem_wr_en_o && flip_mask[mem_addr_o]};
    assign rdata0 = mem0[addr0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < 34; i++) begin
            chk($sformatf("r%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
            chk($sformatf("r%0d_done", i), 32'(done_o), 32'(tbl[i].done));
            chk($sformatf("r%0d_pass", i), 32'(pass_o), 32'(tbl[i].pass));
            chk($sformatf("r%0d_wr", i), 32'(mem_wr_en_o), 32'(tbl[i].wr));
            chk($sformatf("r%0d_addr", i), 32'(mem_addr_o), 32'(tbl[i].addr));
            chk($sformatf("r%0d_data", i), 32'(mem_data_o), 32'(tbl[i].data));
            start_i = tbl[i].start;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string nm, output int n);
        int it = 0;
        n = 0;
        while (!done_o && it < 200) begin
            if (busy_o) n++;
            @(negedge clk);
            it++;
        end
        chk(nm, 32'(done_o), 1);
    endtask

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 34; i++) tbl[i] = '{start: 0, busy: 0, done: 0, pass: 0, wr: 0, addr: 0, data: 0};
        tbl[0].start = 1;
        for (int i = 1; i <= 16; i++) begin
            tbl[i].busy = 1; tbl[i].wr = 1; tbl[i].addr = 4'(i - 1); tbl[i].data = seq[i-1];
        end
        for (int i = 17; i <= 32; i++) begin
            tbl[i].busy = 1; tbl[i].addr = 4'(i - 17);
        end
        tbl[33].done = 1; tbl[33].pass = 1;

        // reset and idle with no start
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_addr", 32'(mem_addr_o), 0);
        reset_n = 1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy_o), 0);
            chk("idle_done", 32'(done_o), 0);
            chk("idle_pass", 32'(pass_o), 0);
            chk("idle_wr", 32'(mem_wr_en_o), 0);
        end

        // clean run, cycle by cycle
        run_table();
        chk("clean_fail_addr", 32'(fail_addr_o), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("ram%0d", i), 32'(mem[i]), 32'(seq[i]));
`ifdef RAM_BIST_ERRCNT_EN
        chk("clean_errcnt", 32'(err_count_o), 0);
`endif

        // faulty read data at addresses 5 and 9, restarted from DONE
        flip_mask = 16'h0220;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        chk("restart_done_low", 32'(done_o), 0);
        chk("restart_pass_low", 32'(pass_o), 0);
        chk("restart_busy", 32'(busy_o), 1);
        wait_done("fault_done", n);
        chk("fault_busy_len", 32'(n), 32);
        chk("fault_pass", 32'(pass_o), 0);
        chk("fault_fail_addr", 32'(fail_addr_o), 5);
`ifdef RAM_BIST_ERRCNT_EN
        chk("fault_errcnt", 32'(err_count_o), 2);
`endif

        // reset asserted in the middle of the read phase at address 7
        flip_mask = '0;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (busy_o && !mem_wr_en_o && mem_addr_o == 7) found = 1;
            else @(negedge clk);
        end
        chk("reach_read7", 32'(found), 1);
        reset_n = 0;
        #1;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_pass", 32'(pass_o), 0);
        chk("abort_addr", 32'(mem_addr_o), 0);
        chk("abort_fail_addr", 32'(fail_addr_o), 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
`ifdef RAM_BIST_ERRCNT_EN
        chk("abort_errcnt", 32'(err_count_o), 0);
`endif
        run_table();
        chk("after_abort_fail_addr", 32'(fail_addr_o), 0);

        // start held high: exactly one run, then immediate restart from DONE
        start_i = 1;
        @(negedge clk);
        wait_done("held_done", n);
        chk("held_busy_len", 32'(n), 32);
        chk("held_pass", 32'(pass_o), 1);
        @(negedge clk);
        start_i = 0;
        chk("held_restart_done", 32'(done_o), 0);
        chk("held_restart_wr", 32'(mem_wr_en_o), 1);
        chk("held_restart_addr", 32'(mem_addr_o), 0);
        chk("held_restart_data", 32'(mem_data_o), 'h01);
        wait_done("held2_done", n);
        chk("held2_busy_len", 32'(n), 32);
        repeat (3) begin
            @(negedge clk);
            chk("done_stays", 32'(done_o), 1);
            chk("done_idle_busy", 32'(busy_o), 0);
        end

        // zero seed is replaced by 1
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        chk("seed0_wr", 32'(wr0), 1);
        chk("seed0_first", 32'(wdata0), 'h01);
        @(negedge clk);
        chk("seed0_second", 32'(wdata0), 'hB8);
        for (int i = 0; i < 100 && !done0; i++) @(negedge clk);
        chk("seed0_done", 32'(done0), 1);
        chk("seed0_pass", 32'(pass0), 1);
        chk("seed0_fail_addr", 32'(fa0), 0);
`ifdef RAM_BIST_ERRCNT_EN
        chk("seed0_errcnt", 32'(err0), 0);
`endif
        chk("seed0_busy_after", 32'(busy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
